// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the game blocks: the game-state encoding
// driven by the game FSM, the keyboard keycodes the game responds to, and
// the internal state encoding of the bird motion engine.
// ----------------------------------------------------------------------------
package game_pkg;

   // Encoding of the game FSM's game_state output; 2'b11 is unused and
   // treated like START by consumers.
   typedef enum logic [1:0] {
      START  = 2'b00,
      ACTIVE = 2'b01,
      OVER   = 2'b10
   } game_state_t;

   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_ENTER = 8'h28;

   // Internal state of the bird motion engine.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_FLY  = 2'b01,
      S_DEAD = 2'b10
   } motion_state_t;

endpackage

// File: rtl/key_edge_detect.sv
// ----------------------------------------------------------------------------
// key_edge_detect
// Turns a level keycode into a registered one-cycle pulse on the rising edge
// of "keycode == KEY". Holding the key produces only the first pulse.
//
// Ports:
//   Clk     - system clock
//   Reset   - synchronous, active-low reset
//   keycode - current keyboard keycode (level, held while pressed)
//   pulse   - one-cycle pulse, one clock after the key first appears
// ----------------------------------------------------------------------------
module key_edge_detect #(
   parameter logic [7:0] KEY = 8'h2C
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   output logic       pulse
);

   logic key_now;
   logic key_prev;

   assign key_now = (keycode == KEY);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         key_prev <= 1'b0;
         pulse    <= 1'b0;
      end else begin
         key_prev <= key_now;
         pulse    <= key_now && !key_prev;
      end
   end

endmodule

// File: rtl/bird_motion.sv
// ----------------------------------------------------------------------------
// bird_motion
// Vertical-motion engine for the player bird. Space presses load an upward
// flap velocity, every frame tick applies gravity (capped at V_MAX) and moves
// the bird, clamped between Y_CEIL and Y_FLOOR. Touching the floor raises
// the sticky is_bottom flag, which the game FSM uses to end the game.
//
// Ports:
//   Clk           - system clock
//   Reset         - synchronous, active-low reset
//   frame_tick    - one-cycle strobe per video frame
//   game_state    - game FSM state (00 start, 01 active, 10 over, 11 = 00)
//   keycode       - current keyboard keycode
//   bird_y        - bird Y position, top of screen = 0
//   is_bottom     - sticky floor-hit flag
//   space_trigger - one-cycle pulse per Space press
// ----------------------------------------------------------------------------
module bird_motion
   import game_pkg::*;
#(
   parameter int Y_START  = 240,
   parameter int Y_FLOOR  = 440,
   parameter int Y_CEIL   = 0,
   parameter int GRAVITY  = 1,
   parameter int FLAP_VEL = -8,
   parameter int V_MAX    = 10
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [1:0] game_state,
   input  logic [7:0] keycode,
   output logic [9:0] bird_y,
   output logic       is_bottom,
   output logic       space_trigger
);

   localparam logic        [9:0]  Y_START10 = 10'(Y_START);
   localparam logic        [9:0]  Y_FLOOR10 = 10'(Y_FLOOR);
   localparam logic        [9:0]  Y_CEIL10  = 10'(Y_CEIL);
   localparam logic signed [10:0] FLOOR11   = 11'(Y_FLOOR);
   localparam logic signed [10:0] CEIL11    = 11'(Y_CEIL);
   localparam logic signed [6:0]  GRAV7     = 7'(GRAVITY);
   localparam logic signed [6:0]  VMAX7     = 7'(V_MAX);
   localparam logic signed [5:0]  VMAX6     = 6'(V_MAX);
   localparam logic signed [5:0]  FLAP6     = 6'(FLAP_VEL);

   motion_state_t     state, state_next;
   logic signed [5:0] v, v_d;
   logic        [9:0] y_d;
   logic              bottom_d;
   logic              flap_req, flap_d;
   logic              rearm;
   logic signed [6:0] v_sum;
   logic signed [5:0] v_new;
   logic signed [10:0] y_next;

   key_edge_detect #(
      .KEY (KEY_SPACE)
   ) u_space_edge (
      .Clk     (Clk),
      .Reset   (Reset),
      .keycode (keycode),
      .pulse   (space_trigger)
   );

   // State and motion registers.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state     <= S_IDLE;
         bird_y    <= Y_START10;
         v         <= '0;
         is_bottom <= 1'b0;
         flap_req  <= 1'b0;
      end else begin
         state     <= state_next;
         bird_y    <= y_d;
         v         <= v_d;
         is_bottom <= bottom_d;
         flap_req  <= flap_d;
      end
   end

   // Candidate velocity and position for the next frame. y_next is 11-bit
   // signed so an overshoot above the ceiling shows up as negative rather
   // than wrapping to a large unsigned Y.
   always_comb begin
      v_sum = {v[5], v} + GRAV7;
      v_new = (v_sum > VMAX7) ? VMAX6 : v_sum[5:0];
      if (flap_req) begin
         v_new = FLAP6;
      end
      y_next = $signed({1'b0, bird_y}) + $signed({{5{v_new[5]}}, v_new});
   end

   // Next-state and motion update. A game_state change in a tick cycle takes
   // priority and suppresses motion. A Space pulse sets flap_req and wins
   // over the clear that happens when an active tick consumes the request.
   always_comb begin
      state_next = state;
      y_d        = bird_y;
      v_d        = v;
      bottom_d   = is_bottom;
      flap_d     = flap_req | space_trigger;
      rearm      = (game_state == START) || (game_state == 2'b11);

      unique case (state)
         S_IDLE: begin
            y_d      = Y_START10;
            v_d      = '0;
            bottom_d = 1'b0;
            flap_d   = 1'b0;
            if (game_state == ACTIVE) begin
               state_next = S_FLY;
            end
         end
         S_FLY: begin
            if (game_state == OVER) begin
               state_next = S_DEAD;
            end else if ((game_state == ACTIVE) && frame_tick) begin
               flap_d = space_trigger;
               if (y_next <= CEIL11) begin
                  y_d = Y_CEIL10;
                  v_d = '0;
               end else if (y_next >= FLOOR11) begin
                  y_d        = Y_FLOOR10;
                  v_d        = '0;
                  bottom_d   = 1'b1;
                  state_next = S_DEAD;
               end else begin
                  y_d = y_next[9:0];
                  v_d = v_new;
               end
            end
         end
         S_DEAD: begin
            state_next = S_DEAD;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Re-arm takes effect on the very next clock, not one cycle after
      // the state register reaches S_IDLE.
      if (rearm) begin
         state_next = S_IDLE;
         y_d        = Y_START10;
         v_d        = '0;
         bottom_d   = 1'b0;
         flap_d     = 1'b0;
      end
   end

endmodule

// File: tb/tb_bird_motion.sv
// ----------------------------------------------------------------------------
// tb_bird_motion
// Directed testbench for bird_motion with hand-computed expected positions.
// ----------------------------------------------------------------------------
module tb_bird_motion;

   logic       Clk;
   logic       Reset;
   logic       frame_tick;
   logic [1:0] game_state;
   logic [7:0] keycode;
   logic [9:0] bird_y;
   logic       is_bottom;
   logic       space_trigger;

   int errors;
   int checks;
   int pulse_cnt;

   bird_motion dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_tick    (frame_tick),
      .game_state    (game_state),
      .keycode       (keycode),
      .bird_y        (bird_y),
      .is_bottom     (is_bottom),
      .space_trigger (space_trigger)
   );

   // 10 ns clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Count space_trigger pulses shortly after each rising edge.
   always @(posedge Clk) begin
      #1;
      if (space_trigger === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (observed !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drive inputs for one clock; called and returns on a falling edge.
   task automatic applyStimulus(input logic [1:0] gs, input logic [7:0] key,
                                input logic tick);
      game_state = gs;
      keycode    = key;
      frame_tick = tick;
      @(negedge Clk);
      frame_tick = 1'b0;
   endtask

   task automatic rearmToFly();
      applyStimulus(2'b00, 8'h00, 1'b0);
      applyStimulus(2'b01, 8'h00, 1'b0);
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      pulse_cnt  = 0;
      Reset      = 1'b0;
      frame_tick = 1'b0;
      game_state = 2'b00;
      keycode    = 8'h00;
      @(negedge Clk);

      // Reset for two cycles, start page.
      applyStimulus(2'b00, 8'h00, 1'b0);
      applyStimulus(2'b00, 8'h00, 1'b0);
      Reset = 1'b1;
      applyStimulus(2'b00, 8'h00, 1'b0);
      checkOutput("reset_y", 32'(bird_y), 240);
      checkOutput("reset_bottom", 32'(is_bottom), 0);
      checkOutput("reset_trigger", 32'(space_trigger), 0);

      // Free fall to the floor.
      applyStimulus(2'b01, 8'h00, 1'b0);
      for (int i = 1; i <= 25; i++) begin
         applyStimulus(2'b01, 8'h00, 1'b1);
         if (i == 1)  checkOutput("fall_t1", 32'(bird_y), 241);
         if (i == 10) checkOutput("fall_t10", 32'(bird_y), 295);
         if (i == 24) begin
            checkOutput("fall_t24", 32'(bird_y), 435);
            checkOutput("fall_t24_bottom", 32'(is_bottom), 0);
         end
      end
      checkOutput("floor_y", 32'(bird_y), 440);
      checkOutput("floor_bottom", 32'(is_bottom), 1);
      applyStimulus(2'b01, 8'h00, 1'b1);
      applyStimulus(2'b01, 8'h00, 1'b1);
      checkOutput("floor_hold_y", 32'(bird_y), 440);
      checkOutput("floor_hold_bottom", 32'(is_bottom), 1);

      // Re-arm from dead, then a held Space and two ticks.
      applyStimulus(2'b00, 8'h00, 1'b0);
      checkOutput("rearm_y", 32'(bird_y), 240);
      checkOutput("rearm_bottom", 32'(is_bottom), 0);
      applyStimulus(2'b01, 8'h00, 1'b0);
      pulse_cnt = 0;
      for (int i = 0; i < 100; i++) applyStimulus(2'b01, 8'h2C, 1'b0);
      applyStimulus(2'b01, 8'h2C, 1'b1);
      checkOutput("flap_t1", 32'(bird_y), 232);
      applyStimulus(2'b01, 8'h2C, 1'b1);
      checkOutput("flap_t2", 32'(bird_y), 225);
      checkOutput("held_pulses", 32'(pulse_cnt), 1);
      applyStimulus(2'b01, 8'h00, 1'b0);

      // A fresh flap before each of 31 ticks: hits and stays at the ceiling.
      rearmToFly();
      pulse_cnt = 0;
      for (int i = 1; i <= 31; i++) begin
         applyStimulus(2'b01, 8'h2C, 1'b0);
         applyStimulus(2'b01, 8'h00, 1'b0);
         applyStimulus(2'b01, 8'h00, 1'b0);
         applyStimulus(2'b01, 8'h00, 1'b1);
         if (i == 1)  checkOutput("ceil_t1", 32'(bird_y), 232);
         if (i == 29) checkOutput("ceil_t29", 32'(bird_y), 8);
         if (i == 30) checkOutput("ceil_t30", 32'(bird_y), 0);
      end
      checkOutput("ceil_t31", 32'(bird_y), 0);
      checkOutput("ceil_pulses", 32'(pulse_cnt), 31);

      // Space rising in the same cycle as a frame tick.
      rearmToFly();
      applyStimulus(2'b01, 8'h2C, 1'b1);
      checkOutput("same_cycle_t1", 32'(bird_y), 241);
      applyStimulus(2'b01, 8'h00, 1'b0);
      applyStimulus(2'b01, 8'h00, 1'b0);
      applyStimulus(2'b01, 8'h00, 1'b1);
      checkOutput("same_cycle_t2", 32'(bird_y), 233);

      // Mid-flight re-arm through game_state.
      applyStimulus(2'b00, 8'h00, 1'b0);
      checkOutput("midflight_gs_y", 32'(bird_y), 240);
      checkOutput("midflight_gs_bottom", 32'(is_bottom), 0);

      // Mid-flight synchronous reset.
      applyStimulus(2'b01, 8'h00, 1'b0);
      applyStimulus(2'b01, 8'h00, 1'b1);
      applyStimulus(2'b01, 8'h00, 1'b1);
      checkOutput("midflight_pre_reset", 32'(bird_y), 243);
      Reset = 1'b0;
      applyStimulus(2'b01, 8'h00, 1'b0);
      Reset = 1'b1;
      checkOutput("midflight_reset_y", 32'(bird_y), 240);
      checkOutput("midflight_reset_bottom", 32'(is_bottom), 0);

      // Game over freezes motion, even with a tick on the change cycle.
      applyStimulus(2'b01, 8'h00, 1'b0);
      applyStimulus(2'b01, 8'h00, 1'b1);
      checkOutput("pre_over_y", 32'(bird_y), 241);
      applyStimulus(2'b10, 8'h00, 1'b1);
      checkOutput("over_change_y", 32'(bird_y), 241);
      applyStimulus(2'b10, 8'h00, 1'b1);
      applyStimulus(2'b10, 8'h00, 1'b1);
      checkOutput("over_hold_y", 32'(bird_y), 241);

      // Space still pulses while frozen.
      pulse_cnt = 0;
      applyStimulus(2'b10, 8'h2C, 1'b0);
      applyStimulus(2'b10, 8'h2C, 1'b0);
      applyStimulus(2'b10, 8'h00, 1'b1);
      checkOutput("over_pulses", 32'(pulse_cnt), 1);
      checkOutput("over_flap_y", 32'(bird_y), 241);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bird_motion.md
# bird_motion

Vertical-motion engine for the player bird. It turns Space-key presses and a per-frame tick into a bird Y position under gravity. It also drives the `is_bottom` and `space_trigger` inputs of the game-state FSM, and follows the FSM's `game_state` output, so it forms the other end of that control loop. It sits between the keyboard and VGA sprite logic and the game FSM.

## Interface
Parameters:
- Y_START, 240: bird Y on the start page and after re-arm.
- Y_FLOOR, 440: lowest legal Y. Reaching it means the bird has hit the ground.
- Y_CEIL, 0: highest legal Y.
- GRAVITY, 1: velocity increment per frame tick.
- FLAP_VEL, -8: signed velocity loaded on a flap.
- V_MAX, 10: terminal (downward) velocity.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- frame_tick, in, 1: one-cycle strobe, once per video frame.
- game_state, in, 2: 00 start page, 01 active, 10 game over, 11 treated as 00.
- keycode, in, 8: current keyboard keycode (level, held while pressed).
- bird_y, out, 10: unsigned bird Y, top = 0.
- is_bottom, out, 1: sticky floor-hit flag.
- space_trigger, out, 1: one-cycle pulse on each Space press (0x2C rising).

## Operation
- Key edge detect:
  - `key_prev <= (keycode == 0x2C)` every cycle.
  - `space_trigger` is registered and equals `(keycode == 0x2C) && !key_prev`.
  - `flap_req` sets on `space_trigger` and clears when consumed by an active frame tick.
- Internal FSM:
  - States: S_IDLE, S_FLY, S_DEAD.
  - S_IDLE to S_FLY when `game_state == 01`.
  - S_FLY to S_DEAD on a floor hit.
  - Any state to S_IDLE when `game_state` is 00 or 11.
  - S_FLY to S_DEAD (freeze) when `game_state == 10`.
- S_IDLE, every cycle: y = Y_START, v = 0, is_bottom = 0, flap_req = 0.
- S_FLY, on frame_tick only:
  - v_new = FLAP_VEL if flap_req, else min(v + GRAVITY, V_MAX).
  - y_next = y + v_new.
  - If y_next <= Y_CEIL: y = Y_CEIL, v = 0.
  - Else if y_next >= Y_FLOOR: y = Y_FLOOR, v = 0, is_bottom = 1.
  - Else: y = y_next, v = v_new.
- S_DEAD: y, v and is_bottom hold. `space_trigger` still pulses.
- Widths:
  - v is 6-bit signed.
  - y_next is computed as 11-bit signed (zero-extend y, sign-extend v) before clamping, so no wrap occurs.
- Reset (Reset == 0 at a clock edge):
  - bird_y = Y_START, v = 0, is_bottom = 0, space_trigger = 0, key_prev = 0, flap_req = 0, state = S_IDLE.
  - Reset mid-flight behaves identically.

## Timing
- `space_trigger` asserts one cycle after keycode first equals 0x2C and lasts exactly one cycle. Holding the key produces no further pulses.
- bird_y and is_bottom update on the clock after the frame_tick cycle. They change in the same cycle as each other.
- Space rising in the same cycle as frame_tick: `flap_req` is not yet set, so that tick applies gravity and the flap applies on the next tick.
- `game_state` change and frame_tick in the same cycle: the state transition wins and no motion update is applied.
- Floor hit and flap on the same tick: the flap is applied first, then the clamp is checked.

## Structure
- Shared package `game_pkg`:
  - `game_state_t` enum: START = 2'b00, ACTIVE = 2'b01, OVER = 2'b10.
  - KEY_SPACE = 8'h2C, KEY_ENTER = 8'h28.
  - The game-state FSM imports the same package.
- Sub-module `key_edge_detect` (parameter KEY): implements the key_prev register and the registered rising-edge pulse. It is reused later for the Enter key.

## Test plan
- Reset low for 2 cycles, then high with game_state = 00: bird_y = 240, is_bottom = 0, space_trigger = 0.
- game_state = 01, no keys, 25 frame ticks:
  - After tick 10: bird_y = 295.
  - After tick 24: bird_y = 435.
  - After tick 25: bird_y = 440 and is_bottom = 1.
  - Further ticks: values hold.
- From y = 240, press Space (held 100 cycles), then 2 ticks: exactly one space_trigger pulse; bird_y = 232 after the first tick and 225 after the second.
- From y = 240, one fresh Space press before each of 31 ticks: bird_y = 0 after tick 30, and stays 0 after tick 31 (no wrap).
- Space rising in the same cycle as a frame_tick: that tick gives bird_y = 241, and the next tick gives bird_y = 233.
- Mid-flight: drive game_state = 00, then separately assert Reset low. Each must return bird_y = 240 and is_bottom = 0 on the next cycle. With game_state = 10, ticks leave bird_y unchanged.
